// File: rtl/line_burst_responder.sv
// Memory-side responder for the cache line interface: one line-aligned read or write-back burst at a time.
// Optional feature: define RESP_STALL_INJECT_EN to insert LFSR-driven bubble cycles inside a burst.
module line_burst_responder #(
  parameter int LINE_WORDS = 16,
  parameter int MEM_AW     = 12,
  parameter int FIRST_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sen,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] sdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic        burst
);

  localparam int DATA_W = 32;
  localparam int BW     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LAT_W  = $clog2(FIRST_LAT) + 1;
  localparam logic [MEM_AW-1:0] BEAT_MASK = MEM_AW'(LINE_WORDS - 1);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    BEAT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              wen_q;
  logic [MEM_AW-1:0] base_q;
  logic [BW-1:0]     beat_q;
  logic [LAT_W-1:0]  lat_q;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  logic              bubble;
  logic              fire;
  logic              last_beat;
  logic [MEM_AW-1:0] idx;
  logic [MEM_AW-1:0] rd_idx;
  logic              rd_en;

  logic [DATA_W-1:0] rd_data_p1;
  logic              rd_vld_p1;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:MEM_AW+2], addr[1:0]};

  assign idx       = base_q + MEM_AW'(beat_q);
  assign last_beat = (beat_q == LAST_BEAT);

`ifdef RESP_STALL_INJECT_EN
  // Bubble source: x^8+x^6+x^5+x^4+1, stepping only while in BEAT.
  logic [7:0] lfsr_q;
  logic [1:0] bub_run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q    <= 8'hA5;
      bub_run_q <= 2'd0;
    end else if (state == BEAT) begin
      lfsr_q    <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      bub_run_q <= bubble ? bub_run_q + 2'd1 : 2'd0;
    end
  end

  assign bubble = (state == BEAT) && lfsr_q[0] && (bub_run_q != 2'd3);
`else
  assign bubble = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    burst     = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: if (sen) state_nxt = ACC;
      ACC: begin
        addr_ok   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (lat_q == '0) state_nxt = BEAT;
      BEAT: begin
        if (!bubble) begin
          fire    = 1'b1;
          data_ok = 1'b1;
          if (last_beat) begin
            burst     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_q    <= '0;
      lat_q     <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ACC) begin
        lat_q <= LAT_W'(FIRST_LAT - 2);
      end else if (state == WAIT && lat_q != '0) begin
        lat_q <= lat_q - 1'b1;
      end
      if (state == WAIT) begin
        beat_q <= '0;
      end else if (fire) begin
        beat_q <= beat_q + 1'b1;
      end
      if (rd_en) rd_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && sen) begin
      wen_q  <= wen;
      base_q <= addr[MEM_AW+1:2] & ~BEAT_MASK;
    end
  end

  // Read stage p1: fetch the word for the upcoming beat one edge ahead, so sdata is a plain register.
  assign rd_en  = !wen_q && (((state == WAIT) && (lat_q == '0)) || (fire && !last_beat));
  assign rd_idx = (state == WAIT) ? base_q : idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rd_en) rd_data_p1 <= mem[rd_idx];
    if (fire && wen_q) mem[idx] <= wdata;
  end

  assign sdata = rd_vld_p1 ? rd_data_p1 : '0;

endmodule

// File: tb/tb_line_burst_responder.sv
// Scoreboard bench for line_burst_responder: expected read beats queued at request time, popped on data_ok.
module tb_line_burst_responder;

  localparam int LW = 16;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sen;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sdata;
  logic        addr_ok;
  logic        data_ok;
  logic        burst;

  logic [31:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  line_burst_responder #(
    .LINE_WORDS(LW),
    .MEM_AW    (12),
    .FIRST_LAT (FL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sen    (sen),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .sdata  (sdata),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .burst  (burst)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] d0);
    for (int i = 0; i < LW; i++) exp_q.push_back(d0 + 32'(i));
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) check({tag, "_underflow"}, 32'd1, 32'd0);
    else check(tag, sdata, exp_q.pop_front());
  endtask

  // One request; abort_beat >= 0 asserts rst in the middle of that write beat.
  task automatic do_burst(input logic w, input logic [31:0] a, input logic [31:0] wb,
                          input int abort_beat);
    int nb, aok_n, aok_c, first_c, burst_c, run, max_run;
    bit done, aborted;
    nb = 0; aok_n = 0; aok_c = -1; first_c = -1; burst_c = -1;
    run = 0; max_run = 0; done = 0; aborted = 0;
    @(negedge clk);
    sen = 1'b1; wen = w; addr = a; wdata = wb;
    @(posedge clk);
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      sen = 1'b0;
      if (addr_ok) begin aok_n++; aok_c = c; end
      if (data_ok) begin
        if (nb == 0) first_c = c;
        run = 0;
        if (w) wdata = wb + 32'(nb);
        else pop_check("rd_data");
        if (w && nb == abort_beat) begin
          rst = 1'b1;
          #1;
          check("rst_data_ok", 32'(data_ok), 32'd0);
          check("rst_burst", 32'(burst), 32'd0);
          check("rst_addr_ok", 32'(addr_ok), 32'd0);
          check("rst_sdata", sdata, 32'd0);
          @(negedge clk);
          rst = 1'b0;
          done = 1; aborted = 1;
        end else begin
          if (burst) begin
            check("burst_beat", 32'(nb), 32'(LW - 1));
            burst_c = c;
            done = 1;
          end
          nb++;
        end
      end else begin
        if (burst) check("burst_wo_data_ok", 32'(burst), 32'd0);
        if (nb > 0) begin
          run++;
          if (run > max_run) max_run = run;
        end
      end
    end
    if (!aborted) begin
      if (!done) check("timeout", 32'd0, 32'd1);
      check("beats", 32'(nb), 32'(LW));
      check("addr_ok_count", 32'(aok_n), 32'd1);
      check("bubble_run_le3", 32'(max_run <= 3), 32'd1);
`ifndef RESP_STALL_INJECT_EN
      check("addr_ok_cycle", 32'(aok_c), 32'd1);
      check("first_data_cycle", 32'(first_c), 32'(FL + 1));
      check("burst_cycle", 32'(burst_c), 32'(FL + LW));
`endif
    end
  endtask

  task automatic back_to_back();
    int aok_n, nburst, bc0, ac1;
    aok_n = 0; nburst = 0; bc0 = -1; ac1 = -1;
    push_line(32'h0000_1000);
    push_line(32'h0000_1000);
    @(negedge clk);
    sen = 1'b1; wen = 1'b0; addr = 32'h0000_0100;
    @(posedge clk);
    for (int c = 1; c <= 300 && nburst < 2; c++) begin
      @(negedge clk);
      if (addr_ok) begin
        aok_n++;
        if (aok_n == 2) begin ac1 = c; sen = 1'b0; end
      end
      if (data_ok) pop_check("b2b_data");
      if (burst) begin
        nburst++;
        if (nburst == 1) begin
          bc0 = c;
          check("b2b_single_addr_ok", 32'(aok_n), 32'd1);
        end
      end
    end
    sen = 1'b0;
    check("b2b_bursts", 32'(nburst), 32'd2);
    check("b2b_addr_ok_total", 32'(aok_n), 32'd2);
    check("b2b_gap", 32'(ac1 - bc0), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sen = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr_ok", 32'(addr_ok), 32'd0);
    check("reset_data_ok", 32'(data_ok), 32'd0);
    check("reset_burst", 32'(burst), 32'd0);
    check("reset_sdata", sdata, 32'd0);
    rst = 1'b0;

    // preload line at 0x100 and read it back
    do_burst(1'b1, 32'h0000_0100, 32'h0000_1000, -1);
    push_line(32'h0000_1000);
    do_burst(1'b0, 32'h0000_0100, 32'd0, -1);

    // write then read
    do_burst(1'b1, 32'h0000_0200, 32'hCAFE_0000, -1);
    push_line(32'hCAFE_0000);
    do_burst(1'b0, 32'h0000_0200, 32'd0, -1);

    // ignored offset bits and bits above the array
    push_line(32'h0000_1000);
    do_burst(1'b0, 32'h0000_013C, 32'd0, -1);
    push_line(32'h0000_1000);
    do_burst(1'b0, 32'h0004_0100, 32'd0, -1);

    back_to_back();

    // reset during beat 5 of a write over a known line
    do_burst(1'b1, 32'h0000_0300, 32'h0000_3000, -1);
    do_burst(1'b1, 32'h0000_0300, 32'hBEEF_0000, 5);
    for (int i = 0; i < LW; i++)
      exp_q.push_back((i < 5) ? 32'hBEEF_0000 + 32'(i) : 32'h0000_3000 + 32'(i));
    do_burst(1'b0, 32'h0000_0300, 32'd0, -1);

    push_line(32'hCAFE_0000);
    do_burst(1'b0, 32'h0000_0200, 32'd0, -1);

    if (exp_q.size() != 0) check("queue_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
